// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_port_arbiter_pkg: shared state encoding and index-width helper.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package ram_port_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int BURST_BITS = 4;

  // Bits needed to hold a client index; never narrower than one bit.
  function automatic int idx_bits(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_port_arbiter_rr_pick: combinational round-robin scan of clients      |
// | 1..N-1, starting at ptr and wrapping back to client 1.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ram_port_arbiter_rr_pick
  import ram_port_arbiter_pkg::*;
#(
  parameter int N = 3,
  parameter int W = idx_bits(N)
) (
  input  logic [N-1:1] pending,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] w_hi_idx;
  logic [W-1:0] w_lo_idx;
  logic         w_hi_found;

  // Descending scan: the last hit is the lowest index, both at/after ptr and overall.
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    found      = 1'b0;
    for (int i = N - 1; i >= 1; i--) begin
      if (pending[i]) begin
        if (W'(i) >= ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = W'(i);
        end
        found    = 1'b1;
        w_lo_idx = W'(i);
      end
    end
    idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_port_arbiter: shares one toggle-handshake RAM port between clients;  |
// | client 0 has burst-limited priority, the rest are served round-robin.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ram_a_bits = 17,
  parameter int clients    = 3,
  parameter int max_burst  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [clients*ram_a_bits-1:0]   c_a,
  input  logic [clients*8-1:0]            c_d,
  input  logic [clients-1:0]              c_we,
  input  logic [clients-1:0]              c_req,
  output logic [clients-1:0]              c_ack,
  output logic [clients*8-1:0]            c_q,
  output logic [ram_a_bits-1:0]           ram_a,
  output logic [7:0]                      ram_d,
  output logic                            ram_we,
  output logic                            ram_req,
  input  logic                            ram_ack,
  input  logic [7:0]                      ram_q
);

  localparam int                    IW          = idx_bits(clients);
  localparam logic [BURST_BITS-1:0] BURST_MAX   = BURST_BITS'(max_burst);
  localparam logic [IW-1:0]         FIRST_RR    = IW'(1);
  localparam logic [IW-1:0]         LAST_CLIENT = IW'(clients - 1);

  state_t                  r_state;
  logic                    r_ram_req;
  logic                    r_ram_we;
  logic [ram_a_bits-1:0]   r_ram_a;
  logic [7:0]              r_ram_d;
  logic [clients-1:0]      r_c_ack;
  logic [7:0]              r_c_q [clients];
  logic [BURST_BITS-1:0]   r_burst;
  logic [IW-1:0]           r_rr_ptr;
  logic [IW-1:0]           r_winner;

  logic [ram_a_bits-1:0]   w_a [clients];
  logic [7:0]              w_d [clients];
  logic [clients-1:0]      w_pend;
  logic                    w_others;
  logic                    w_c0_win;
  logic                    w_rr_found;
  logic                    w_grant;
  logic [IW-1:0]           w_rr_idx;
  logic [IW-1:0]           w_win_idx;

  for (genvar g = 0; g < clients; g++) begin : g_client
    assign w_a[g]         = c_a[g*ram_a_bits +: ram_a_bits];
    assign w_d[g]         = c_d[g*8 +: 8];
    assign c_q[g*8 +: 8]  = r_c_q[g];
  end

  assign w_pend   = c_req ^ r_c_ack;
  assign w_others = |w_pend[clients-1:1];
  // Client 0 yields only once its burst allowance is spent and someone else waits.
  assign w_c0_win  = w_pend[0] && !(w_others && (r_burst == BURST_MAX));
  assign w_grant   = w_c0_win || w_rr_found;
  assign w_win_idx = w_c0_win ? '0 : w_rr_idx;

  ram_port_arbiter_rr_pick #(
    .N (clients),
    .W (IW)
  ) u_rr_pick (
    .pending (w_pend[clients-1:1]),
    .ptr     (r_rr_ptr),
    .idx     (w_rr_idx),
    .found   (w_rr_found)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_ram_req <= 1'b0;
      r_ram_we  <= 1'b0;
      r_ram_a   <= '0;
      r_ram_d   <= '0;
      r_c_ack   <= '0;
      r_burst   <= '0;
      r_rr_ptr  <= FIRST_RR;
      r_winner  <= '0;
      for (int i = 0; i < clients; i++) begin
        r_c_q[i] <= '0;
      end
    end else begin
      if (!w_others) begin
        r_burst <= '0;
      end else if ((r_state == ST_IDLE) && w_grant) begin
        if (w_c0_win) begin
          r_burst <= (r_burst == BURST_MAX) ? BURST_MAX : r_burst + 1'b1;
        end else begin
          r_burst <= '0;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_ram_a   <= w_a[w_win_idx];
            r_ram_we  <= c_we[w_win_idx];
            r_ram_d   <= w_d[w_win_idx];
            r_ram_req <= ~r_ram_req;
            r_winner  <= w_win_idx;
            r_state   <= ST_WAIT;
            if (!w_c0_win) begin
              r_rr_ptr <= (w_rr_idx == LAST_CLIENT) ? FIRST_RR : w_rr_idx + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (ram_ack == r_ram_req) begin
            if (!r_ram_we) begin
              r_c_q[r_winner] <= ram_q;
            end
            r_c_ack[r_winner] <= ~r_c_ack[r_winner];
            r_state           <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign c_ack   = r_c_ack;
  assign ram_a   = r_ram_a;
  assign ram_d   = r_ram_d;
  assign ram_we  = r_ram_we;
  assign ram_req = r_ram_req;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ram_port_arbiter: directed bench with a transaction-level model.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ram_port_arbiter;

  localparam int AB = 17;
  localparam int CL = 3;
  localparam int MB = 4;
  localparam logic [AB-1:0] A0 = 17'h00100;
  localparam logic [AB-1:0] A1 = 17'h00201;
  localparam logic [AB-1:0] A2 = 17'h00302;
  localparam logic [AB-1:0] A6 = 17'h00ABC;

  logic              clk;
  logic              reset_n;
  logic [CL*AB-1:0]  c_a;
  logic [CL*8-1:0]   c_d;
  logic [CL-1:0]     c_we;
  logic [CL-1:0]     c_req;
  logic [CL-1:0]     c_ack;
  logic [CL*8-1:0]   c_q;
  logic [AB-1:0]     ram_a;
  logic [7:0]        ram_d;
  logic              ram_we;
  logic              ram_req;
  logic              ram_ack;
  logic [7:0]        ram_q;

  int total = 0;
  int bad   = 0;

  ram_port_arbiter #(
    .ram_a_bits (AB),
    .clients    (CL),
    .max_burst  (MB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .c_a     (c_a),
    .c_d     (c_d),
    .c_we    (c_we),
    .c_req   (c_req),
    .c_ack   (c_ack),
    .c_q     (c_q),
    .ram_a   (ram_a),
    .ram_d   (ram_d),
    .ram_we  (ram_we),
    .ram_req (ram_req),
    .ram_ack (ram_ack),
    .ram_q   (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // RAM responder: fixed latency in cycles, reset together with the arbiter.
  logic [7:0] mem [0:(1<<AB)-1];
  int ram_lat = 3;
  int ram_cnt = 0;
  initial begin
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n) begin
        ram_ack = 1'b0;
        ram_cnt = 0;
      end else if (ram_req != ram_ack) begin
        ram_cnt++;
        if (ram_cnt >= ram_lat) begin
          if (ram_we) mem[ram_a] = ram_d;
          else        ram_q = mem[ram_a];
          ram_ack = ram_req;
          ram_cnt = 0;
        end
      end
    end
  end

  // Transaction-level model: the port is either free or owned by one client.
  logic [CL-1:0] m_ack;
  logic [7:0]    m_q [CL];
  logic          m_req;
  logic          m_we;
  logic [AB-1:0] m_a;
  logic [7:0]    m_d;
  bit            m_busy;
  int            m_owner;
  int            m_run;
  int            m_rr;
  logic [CL-1:0] m_pend;
  int            m_w;

  function automatic int choose(input logic [CL-1:0] pend, input int run, input int rr);
    bit others;
    int c;
    others = (pend >> 1) != 0;
    if (pend[0] && !(others && run >= MB)) return 0;
    for (int k = 0; k < CL - 1; k++) begin
      c = 1 + (rr - 1 + k) % (CL - 1);
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_ack = '0; m_req = 1'b0; m_we = 1'b0; m_a = '0; m_d = '0;
        m_busy = 0; m_owner = 0; m_run = 0; m_rr = 1;
        for (int i = 0; i < CL; i++) m_q[i] = 8'h00;
      end else begin
        m_pend = c_req ^ m_ack;
        if (!m_busy && m_pend != 0) begin
          m_w = choose(m_pend, m_run, m_rr);
          if (m_w >= 0) begin
            m_a     = c_a[m_w*AB +: AB];
            m_we    = c_we[m_w];
            m_d     = c_d[m_w*8 +: 8];
            m_req   = ~m_req;
            m_owner = m_w;
            m_busy  = 1;
            if (m_w != 0) m_rr = (m_w % (CL - 1)) + 1;
            m_run = (m_w == 0) ? m_run + 1 : 0;
          end
        end else if (m_busy && ram_ack == m_req) begin
          if (!m_we) m_q[m_owner] = ram_q;
          m_ack[m_owner] = ~m_ack[m_owner];
          m_busy = 0;
        end
        if ((m_pend >> 1) == 0) m_run = 0;
      end
    end
  end

  logic [CL*8-1:0] m_qv;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < CL; i++) m_qv[i*8 +: 8] = m_q[i];
    chk("model_ram_req", ram_req, m_req);
    chk("model_ram_a",   ram_a,   m_a);
    chk("model_ram_we",  ram_we,  m_we);
    chk("model_ram_d",   ram_d,   m_d);
    chk("model_c_ack",   c_ack,   m_ack);
    chk("model_c_q",     c_q,     m_qv);
  end

  // Grant log: one entry per ram_req toggle.
  typedef struct packed {
    logic [AB-1:0] a;
    logic          we;
    logic [7:0]    d;
  } grant_t;
  grant_t glog[$];
  logic   last_req = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) last_req = 1'b0;
      else if (ram_req != last_req) begin
        glog.push_back({ram_a, ram_we, ram_d});
        last_req = ram_req;
      end
    end
  end

  task automatic req(input int i, input logic [AB-1:0] a, input logic we, input logic [7:0] d);
    c_a[i*AB +: AB] = a;
    c_d[i*8 +: 8]   = d;
    c_we[i]         = we;
    c_req[i]        = ~c_req[i];
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (c_req != c_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, c_ack, c_req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [AB-1:0] exp_seq [6];
  int n0;
  int nw;

  initial begin
    reset_n = 1'b0;
    c_req = '0; c_a = '0; c_d = '0; c_we = '0;
    ram_q = 8'h00; ram_ack = 1'b0;
    for (int i = 0; i < (1 << AB); i++) mem[i] = 8'h00;
    mem[17'h01234] = 8'hA5;
    mem[A0] = 8'h10; mem[A1] = 8'h11; mem[A2] = 8'h12; mem[A6] = 8'h77;
    repeat (3) @(negedge clk);
    chk("rst_ram_req", ram_req, 1'b0);
    chk("rst_ram_a",   ram_a,   '0);
    chk("rst_c_ack",   c_ack,   3'b000);
    chk("rst_c_q",     c_q,     24'h000000);
    reset_n = 1'b1;

    // Single read by client 2
    @(negedge clk);
    req(2, 17'h01234, 1'b0, 8'h00);
    @(posedge clk); #1;
    chk("t1_ram_req", ram_req, 1'b1);
    chk("t1_ram_a",   ram_a,   17'h01234);
    chk("t1_ram_we",  ram_we,  1'b0);
    nw = 0;
    while (ram_ack != ram_req && nw < 20) begin
      @(negedge clk); #1;
      nw++;
    end
    chk("t1_ram_ack",    ram_ack,  1'b1);
    chk("t1_ack_early",  c_ack[2], 1'b0);
    @(posedge clk); #1;
    chk("t1_c_ack",  c_ack,       3'b100);
    chk("t1_c_q2",   c_q[23:16],  8'hA5);

    // Simultaneous requests from all clients
    @(negedge clk);
    glog.delete();
    req(0, A0, 1'b0, 8'h00);
    req(1, A1, 1'b0, 8'h00);
    req(2, A2, 1'b0, 8'h00);
    wait_idle("t2_idle");
    chk("t2_ngrant", glog.size(), 3);
    chk("t2_g0", (glog.size() > 0) ? glog[0].a : '0, A0);
    chk("t2_g1", (glog.size() > 1) ? glog[1].a : '0, A1);
    chk("t2_g2", (glog.size() > 2) ? glog[2].a : '0, A2);
    chk("t2_c_ack", c_ack, 3'b011);
    chk("t2_c_q",   c_q,   24'h121110);

    // Starvation guard: client 0 keeps re-requesting while client 1 waits
    @(negedge clk);
    glog.delete();
    ram_lat = 1;
    req(1, A1, 1'b0, 8'h00);
    req(0, A0, 1'b0, 8'h00);
    n0 = 1;
    for (int cyc = 0; cyc < 400 && !(n0 == 5 && c_req == c_ack); cyc++) begin
      @(negedge clk);
      if (c_req[0] == c_ack[0] && n0 < 5) begin
        req(0, A0, 1'b0, 8'h00);
        n0++;
      end
    end
    chk("t3_done", c_ack, c_req);
    exp_seq = '{A0, A0, A0, A0, A1, A0};
    chk("t3_ngrant", glog.size(), 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t3_grant%0d", k), (k < glog.size()) ? glog[k].a : '0, exp_seq[k]);
    chk("t3_c_ack", c_ack, 3'b000);
    ram_lat = 3;

    // Write by client 1, then read back by client 2
    @(negedge clk);
    glog.delete();
    req(1, 17'h1FFFF, 1'b1, 8'h3C);
    wait_idle("t4_idle_w");
    @(negedge clk);
    req(2, 17'h1FFFF, 1'b0, 8'h00);
    wait_idle("t4_idle_r");
    chk("t4_ngrant", glog.size(), 2);
    chk("t4_we0", (glog.size() > 0) ? glog[0].we : 1'b0, 1'b1);
    chk("t4_d0",  (glog.size() > 0) ? glog[0].d  : 8'h00, 8'h3C);
    chk("t4_we1", (glog.size() > 1) ? glog[1].we : 1'b1, 1'b0);
    chk("t4_a1",  (glog.size() > 1) ? glog[1].a  : '0, 17'h1FFFF);
    chk("t4_c_q2", c_q[23:16], 8'h3C);
    chk("t4_c_q1", c_q[15:8],  8'h11);
    chk("t4_c_ack", c_ack, 3'b110);

    // Reset while the port is waiting on the RAM
    @(negedge clk);
    req(1, A1, 1'b0, 8'h00);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    c_req   = '0;
    #1;
    chk("t5_ram_req", ram_req, 1'b0);
    chk("t5_ram_a",   ram_a,   '0);
    chk("t5_ram_we",  ram_we,  1'b0);
    chk("t5_ram_d",   ram_d,   8'h00);
    chk("t5_c_ack",   c_ack,   3'b000);
    chk("t5_c_q",     c_q,     24'h000000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    req(1, A6, 1'b0, 8'h00);
    wait_idle("t5_idle");
    chk("t5_after_c_q",   c_q,   24'h007700);
    chk("t5_after_c_ack", c_ack, 3'b010);

    // Double toggle of client 2 while the port is busy
    @(negedge clk);
    glog.delete();
    req(1, A6, 1'b0, 8'h00);
    @(negedge clk);
    c_req[2] = ~c_req[2];
    @(negedge clk);
    c_req[2] = ~c_req[2];
    wait_idle("t6_idle");
    repeat (4) @(negedge clk);
    chk("t6_ngrant", glog.size(), 1);
    chk("t6_c_ack",  c_ack, 3'b000);
    chk("t6_c_q2",   c_q[23:16], 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
